barrel_shifter: RTL and testbench

//  ARM-style operand-2 generator for the CPU execute stage. Produces the second ALU

---
 rtl/barrel_shifter_pkg.sv | 21 ++
 rtl/barrel_shifter_if.sv | 27 ++
 rtl/barrel_shifter_core.sv | 65 ++++++
 rtl/barrel_shifter.sv | 45 ++++
 tb/tb_barrel_shifter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared word width, shift-type codes and a rotate helper for the operand-2 shifter.
package barrel_shifter_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  // Rotate right by taking the low half of the doubled word shifted down.
  function automatic logic [WORD_WIDTH-1:0] ror_word(input logic [WORD_WIDTH-1:0] v,
                                                     input logic [4:0] amt);
    logic [2*WORD_WIDTH-1:0] d;
    d = {v, v} >> amt;
    return d[WORD_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/barrel_shifter_if.sv
// Operand and result bundle between the execute stage and the operand-2 shifter.
interface barrel_shifter_if;
  import barrel_shifter_pkg::*;

  logic [WORD_WIDTH-1:0] in_Reg_val;
  logic [WORD_WIDTH-1:0] in_Imm_val;
  logic [4:0]            in_Shift_val;
  logic [3:0]            in_Rotate;
  logic [1:0]            in_Shift_type;
  logic                  in_Imm_sel;
  logic                  in_C_flag;
  logic [WORD_WIDTH-1:0] out_Op2;
  logic                  out_Carry;

  modport master (
    output in_Reg_val, in_Imm_val, in_Shift_val, in_Rotate, in_Shift_type,
           in_Imm_sel, in_C_flag,
    input  out_Op2, out_Carry
  );

  modport slave (
    input  in_Reg_val, in_Imm_val, in_Shift_val, in_Rotate, in_Shift_type,
           in_Imm_sel, in_C_flag,
    output out_Op2, out_Carry
  );

endinterface

// File: rtl/barrel_shifter_core.sv
// Combinational operand-2 generator: register shift/rotate or rotated 8-bit immediate,
// plus the shifter carry-out.
module shifter_core
  import barrel_shifter_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] i_reg_val,
  input  logic [7:0]            i_imm8,
  input  logic [4:0]            i_shift_val,
  input  logic [3:0]            i_rotate,
  input  logic [1:0]            i_shift_type,
  input  logic                  i_imm_sel,
  input  logic                  i_c_flag,
  output logic [WORD_WIDTH-1:0] o_op2,
  output logic                  o_carry
);

  // Shifts done one bit wider so the last bit shifted out lands in the extra bit.
  logic [WORD_WIDTH:0]   w_lsl;
  logic [WORD_WIDTH:0]   w_lsr;
  logic [WORD_WIDTH:0]   w_asr;
  logic [WORD_WIDTH-1:0] w_ror;
  logic [WORD_WIDTH-1:0] w_imm_rot;
  logic                  w_zero_amt;

  assign w_lsl      = {1'b0, i_reg_val} << i_shift_val;
  assign w_lsr      = {i_reg_val, 1'b0} >> i_shift_val;
  assign w_asr      = $signed({i_reg_val, 1'b0}) >>> i_shift_val;
  assign w_ror      = ror_word(i_reg_val, i_shift_val);
  assign w_imm_rot  = ror_word({24'b0, i_imm8}, {i_rotate, 1'b0});
  assign w_zero_amt = (i_shift_val == 5'd0);

  always_comb begin
    o_op2   = '0;
    o_carry = 1'b0;
    if (i_imm_sel) begin
      o_op2   = w_imm_rot;
      o_carry = (i_rotate == 4'd0) ? i_c_flag : w_imm_rot[WORD_WIDTH-1];
    end else begin
      case (shift_type_e'(i_shift_type))
        SHIFT_LSL: begin
          o_op2   = w_zero_amt ? i_reg_val : w_lsl[WORD_WIDTH-1:0];
          o_carry = w_zero_amt ? i_c_flag  : w_lsl[WORD_WIDTH];
        end
        // A zero amount encodes a shift by 32 for LSR and ASR.
        SHIFT_LSR: begin
          o_op2   = w_zero_amt ? '0 : w_lsr[WORD_WIDTH:1];
          o_carry = w_zero_amt ? i_reg_val[WORD_WIDTH-1] : w_lsr[0];
        end
        SHIFT_ASR: begin
          o_op2   = w_zero_amt ? {WORD_WIDTH{i_reg_val[WORD_WIDTH-1]}} : w_asr[WORD_WIDTH:1];
          o_carry = w_zero_amt ? i_reg_val[WORD_WIDTH-1] : w_asr[0];
        end
        SHIFT_ROR: begin
          o_op2   = w_zero_amt ? {i_c_flag, i_reg_val[WORD_WIDTH-1:1]} : w_ror;
          o_carry = w_zero_amt ? i_reg_val[0] : w_ror[WORD_WIDTH-1];
        end
        default: begin
          o_op2   = '0;
          o_carry = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Operand-2 shifter top: combinational core followed by a single output register stage
// with asynchronous active-low reset.
module barrel_shifter
  import barrel_shifter_pkg::*;
(
  input  logic          in_Clk,
  input  logic          in_Rst_n,
  barrel_shifter_if.slave bs
);

  logic [WORD_WIDTH-1:0] w_op2_next;
  logic                  w_carry_next;
  logic [WORD_WIDTH-1:0] r_op2;
  logic                  r_carry;
  logic                  w_unused_imm_hi;

  // Only the low byte of the immediate is meaningful.
  assign w_unused_imm_hi = ^bs.in_Imm_val[WORD_WIDTH-1:8];

  shifter_core u_core (
    .i_reg_val    (bs.in_Reg_val),
    .i_imm8       (bs.in_Imm_val[7:0]),
    .i_shift_val  (bs.in_Shift_val),
    .i_rotate     (bs.in_Rotate),
    .i_shift_type (bs.in_Shift_type),
    .i_imm_sel    (bs.in_Imm_sel),
    .i_c_flag     (bs.in_C_flag),
    .o_op2        (w_op2_next),
    .o_carry      (w_carry_next)
  );

  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      r_op2   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_op2   <= w_op2_next;
      r_carry <= w_carry_next;
    end
  end

  assign bs.out_Op2   = r_op2;
  assign bs.out_Carry = r_carry;

endmodule

// File: tb/tb_barrel_shifter.sv
// Randomized and directed check of the registered operand-2 shifter against an
// arithmetic reference model.
module tb_barrel_shifter;

  logic in_Clk;
  logic in_Rst_n;
  int   n_compared;
  int   n_mismatched;

  barrel_shifter_if bs ();

  barrel_shifter dut (
    .in_Clk   (in_Clk),
    .in_Rst_n (in_Rst_n),
    .bs       (bs)
  );

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on 64-bit values, returns {carry, op2}.
  function automatic logic [32:0] ref_model(input logic [31:0] r, input logic [31:0] imm,
                                            input logic [4:0] n, input logic [3:0] rot,
                                            input logic [1:0] t, input logic is_imm,
                                            input logic c_in);
    longint unsigned rr;
    longint unsigned v;
    longint unsigned mask;
    longint unsigned op;
    longint unsigned c;
    int a;
    rr   = r;
    mask = 64'hFFFF_FFFF;
    op   = 0;
    c    = 0;
    if (is_imm) begin
      a  = 2 * rot;
      v  = imm % 256;
      op = ((v >> a) | (v << (32 - a))) & mask;
      c  = (rot == 0) ? c_in : (op >> 31) & 1;
    end else begin
      case (t)
        2'd0: begin
          if (n == 0) begin op = rr; c = c_in; end
          else begin op = (rr << n) & mask; c = (rr >> (32 - n)) & 1; end
        end
        2'd1: begin
          if (n == 0) begin op = 0; c = rr / 64'h8000_0000; end
          else begin op = rr >> n; c = (rr >> (n - 1)) & 1; end
        end
        2'd2: begin
          if (n == 0) begin
            op = (rr >= 64'h8000_0000) ? mask : 0;
            c  = rr / 64'h8000_0000;
          end else begin
            op = (rr >= 64'h8000_0000) ? (~((~rr & mask) >> n)) & mask : rr >> n;
            c  = (rr >> (n - 1)) & 1;
          end
        end
        default: begin
          if (n == 0) begin op = c_in * 64'h8000_0000 + rr / 2; c = rr % 2; end
          else begin op = ((rr >> n) | (rr << (32 - n))) & mask; c = (op >> 31) & 1; end
        end
      endcase
    end
    return {c[0], op[31:0]};
  endfunction

  task automatic drive(input logic [31:0] r, input logic [31:0] imm, input logic [4:0] n,
                       input logic [3:0] rot, input logic [1:0] t, input logic is_imm,
                       input logic c_in);
    bs.in_Reg_val    = r;
    bs.in_Imm_val    = imm;
    bs.in_Shift_val  = n;
    bs.in_Rotate     = rot;
    bs.in_Shift_type = t;
    bs.in_Imm_sel    = is_imm;
    bs.in_C_flag     = c_in;
  endtask

  // Directed vector: apply at negedge, check spec value one edge later.
  task automatic directed(input string tag, input logic [31:0] r, input logic [31:0] imm,
                          input logic [4:0] n, input logic [3:0] rot, input logic [1:0] t,
                          input logic is_imm, input logic c_in,
                          input logic [31:0] exp_op, input logic exp_c);
    @(negedge in_Clk);
    drive(r, imm, n, rot, t, is_imm, c_in);
    @(posedge in_Clk);
    #1;
    check({tag, "_op2"}, bs.out_Op2, exp_op);
    check({tag, "_carry"}, {31'b0, bs.out_Carry}, {31'b0, exp_c});
  endtask

  logic [32:0] exp_v;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    in_Rst_n     = 1'b0;
    drive(32'h1234_5678, 32'hFFFF_FFAB, 5'd3, 4'd1, 2'd0, 1'b0, 1'b1);
    repeat (2) @(posedge in_Clk);
    #1;
    check("reset_op2", bs.out_Op2, 32'h0);
    check("reset_carry", {31'b0, bs.out_Carry}, 32'h0);
    @(negedge in_Clk);
    in_Rst_n = 1'b1;

    directed("lsl1",  32'd2, 32'd0, 5'd1, 4'd0, 2'b00, 1'b0, 1'b0, 32'd4, 1'b0);
    directed("lsl0",  32'd2, 32'd0, 5'd0, 4'd0, 2'b00, 1'b0, 1'b1, 32'd2, 1'b1);
    directed("lsr1",  32'd2, 32'd0, 5'd1, 4'd0, 2'b01, 1'b0, 1'b1, 32'd1, 1'b0);
    directed("lsr0",  32'd2, 32'd0, 5'd0, 4'd0, 2'b01, 1'b0, 1'b1, 32'd0, 1'b0);
    directed("asr10", 32'd13244, 32'd0, 5'd10, 4'd0, 2'b10, 1'b0, 1'b0, 32'd12, 1'b1);
    directed("asr0",  32'hFFB4_C180, 32'd0, 5'd0, 4'd0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    directed("ror4",  32'd200, 32'd0, 5'd4, 4'd0, 2'b11, 1'b0, 1'b1, 32'h8000_000C, 1'b1);
    directed("rrx_c0", 32'd200, 32'd0, 5'd0, 4'd0, 2'b11, 1'b0, 1'b0, 32'd100, 1'b0);
    directed("rrx_c1", 32'd200, 32'd0, 5'd0, 4'd0, 2'b11, 1'b0, 1'b1, 32'h8000_0064, 1'b0);
    directed("imm_rot4", 32'hDEAD_BEEF, 32'h0000_00FF, 5'd7, 4'd4, 2'b01, 1'b1, 1'b0,
             32'hFF00_0000, 1'b1);
    directed("imm_rot0", 32'hDEAD_BEEF, 32'hABCD_EF05, 5'd9, 4'd0, 2'b10, 1'b1, 1'b1,
             32'd5, 1'b1);
    directed("lsl31", 32'h0000_0003, 32'd0, 5'd31, 4'd0, 2'b00, 1'b0, 1'b0, 32'h8000_0000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r, imm;
      logic [4:0]  n;
      logic [3:0]  rot;
      logic [1:0]  t;
      logic        is_imm, c_in;
      r      = $urandom;
      imm    = $urandom;
      n      = 5'($urandom_range(0, 31));
      rot    = 4'($urandom_range(0, 15));
      t      = 2'($urandom_range(0, 3));
      is_imm = 1'($urandom_range(0, 1));
      c_in   = 1'($urandom_range(0, 1));
      if ((i % 8) == 0) n = 5'd0;
      @(negedge in_Clk);
      drive(r, imm, n, rot, t, is_imm, c_in);
      exp_v = ref_model(r, imm, n, rot, t, is_imm, c_in);
      @(posedge in_Clk);
      #1;
      check($sformatf("rand%0d_op2", i), bs.out_Op2, exp_v[31:0]);
      check($sformatf("rand%0d_carry", i), {31'b0, bs.out_Carry}, {31'b0, exp_v[32]});
    end

    // Asynchronous reset asserted between edges, then released.
    @(negedge in_Clk);
    drive(32'hF000_0001, 32'd0, 5'd4, 4'd0, 2'b11, 1'b0, 1'b0);
    @(posedge in_Clk);
    #1;
    check("pre_areset_op2", bs.out_Op2, 32'h1F00_0000);
    #2;
    in_Rst_n = 1'b0;
    #1;
    check("areset_op2", bs.out_Op2, 32'h0);
    check("areset_carry", {31'b0, bs.out_Carry}, 32'h0);
    @(posedge in_Clk);
    #1;
    check("areset_hold_op2", bs.out_Op2, 32'h0);
    @(negedge in_Clk);
    in_Rst_n = 1'b1;
    #1;
    check("release_nochange", bs.out_Op2, 32'h0);
    @(posedge in_Clk);
    #1;
    check("release_load_op2", bs.out_Op2, 32'h1F00_0000);
    check("release_load_carry", {31'b0, bs.out_Carry}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
